// File: rtl/rdmx_pkg.sv
// Shared constants for the RDMX receive back end.
//   BPB, BEAT_WBITS, MAX_PLEN : beat geometry for the default 512-bit datapath
//   AXI_BURST_INCR, AXI_RESP_OKAY : AXI4 encodings used on the write channels
//   ST_* : controller state encodings
package rdmx_pkg;

  localparam int DATA_WBITS_DEF = 512;
  localparam int BPB            = DATA_WBITS_DEF / 8;
  localparam int BEAT_WBITS     = $clog2(BPB);
  localparam int MAX_PLEN       = 256 * BPB;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_AW      = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_PAD     = 3'd3;
  localparam logic [2:0] ST_DRAIN_W = 3'd4;
  localparam logic [2:0] ST_DRAIN   = 3'd5;
  localparam logic [2:0] ST_RESP    = 3'd6;

endpackage

// File: rtl/rdmx_strb_gen.sv
// Last-beat write strobe generator.
//   rem  : packet length modulo bytes-per-beat
//   strb : low 'rem' byte lanes enabled; rem == 0 means the last beat is full
module rdmx_strb_gen #(
  parameter int BYTES = 64
) (
  input  logic [$clog2(BYTES)-1:0] rem,
  output logic [BYTES-1:0]         strb
);

  localparam logic [BYTES-1:0] ONE = BYTES'(1);

  always_comb begin
    strb = '1;
    if (rem != '0) strb = (ONE << rem) - ONE;
  end

endmodule

// File: rtl/rdmx_recv_be.sv
// RDMX receive back end: turns an (address, length, data) AXI-Stream triplet
// into one AXI4 INCR write burst per packet, waiting for B before the next.
//   clk, resetn            : clock, asynchronous active-low reset
//   AXIS_ADDR_* / PLEN_*   : packet header streams, accepted together
//   AXIS_DATA_*            : packet payload stream, TLAST marks the final beat
//   M_AXI_AW* / W* / B*    : AXI4 write master (single burst in flight)
//   length_err, bresp_err  : single-cycle error pulses
//   busy                   : controller not idle
//   pkt_count, err_count   : statistics, present only when the build defines
//                            RDMX_RECV_BE_STATS_EN (otherwise tied to zero)
module rdmx_recv_be
  import rdmx_pkg::*;
#(
  parameter int DATA_WBITS = DATA_WBITS_DEF,
  parameter int ADDR_WBITS = 64,
  parameter int AXI_ID     = 0
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic [ADDR_WBITS-1:0]   AXIS_ADDR_TDATA,
  input  logic                    AXIS_ADDR_TVALID,
  output logic                    AXIS_ADDR_TREADY,
  input  logic [15:0]             AXIS_PLEN_TDATA,
  input  logic                    AXIS_PLEN_TVALID,
  output logic                    AXIS_PLEN_TREADY,
  input  logic [DATA_WBITS-1:0]   AXIS_DATA_TDATA,
  input  logic                    AXIS_DATA_TLAST,
  input  logic                    AXIS_DATA_TVALID,
  output logic                    AXIS_DATA_TREADY,
  output logic [ADDR_WBITS-1:0]   M_AXI_AWADDR,
  output logic [7:0]              M_AXI_AWLEN,
  output logic [2:0]              M_AXI_AWSIZE,
  output logic [1:0]              M_AXI_AWBURST,
  output logic [3:0]              M_AXI_AWID,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,
  output logic [DATA_WBITS-1:0]   M_AXI_WDATA,
  output logic [DATA_WBITS/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WLAST,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,
  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,
  output logic                    length_err,
  output logic                    bresp_err,
  output logic                    busy,
  output logic [31:0]             pkt_count,
  output logic [31:0]             err_count
);

  localparam int          BYTES    = DATA_WBITS / 8;
  localparam int          BEAT_W   = $clog2(BYTES);
  localparam logic [16:0] PLEN_MAX = 17'(256 * BYTES);

  logic [2:0]            state_q, state_d;
  logic [7:0]            beat_q, beat_d;
  logic                  run_q, run_d;
  logic [ADDR_WBITS-1:0] addr_q, addr_d;
  logic [7:0]            awlen_q, awlen_d;
  logic [BEAT_W-1:0]     rem_q, rem_d;
  logic [BYTES-1:0]      last_strb;
  logic [15:0]           plen_m1;
  logic                  plen_ok, last_beat, hdr_rdy;

  rdmx_strb_gen #(.BYTES(BYTES)) u_strb_gen (
    .rem  (rem_q),
    .strb (last_strb)
  );

  assign plen_ok   = (AXIS_PLEN_TDATA != 16'd0) && ({1'b0, AXIS_PLEN_TDATA} <= PLEN_MAX);
  assign plen_m1   = AXIS_PLEN_TDATA - 16'd1;
  assign last_beat = (beat_q == awlen_q);
  assign run_d     = 1'b1;

  always_comb begin
    state_d          = state_q;
    beat_d           = beat_q;
    addr_d           = addr_q;
    awlen_d          = awlen_q;
    rem_d            = rem_q;
    hdr_rdy          = 1'b0;
    AXIS_DATA_TREADY = 1'b0;
    M_AXI_AWVALID    = 1'b0;
    M_AXI_AWADDR     = '0;
    M_AXI_AWLEN      = '0;
    M_AXI_AWSIZE     = '0;
    M_AXI_AWBURST    = '0;
    M_AXI_AWID       = '0;
    M_AXI_WVALID     = 1'b0;
    M_AXI_WDATA      = '0;
    M_AXI_WSTRB      = '0;
    M_AXI_WLAST      = 1'b0;
    M_AXI_BREADY     = 1'b0;
    length_err       = 1'b0;
    bresp_err        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // run_q keeps the header streams stalled until the first edge after reset.
        hdr_rdy = run_q && AXIS_ADDR_TVALID && AXIS_PLEN_TVALID;
        if (hdr_rdy) begin
          if (plen_ok) begin
            addr_d  = AXIS_ADDR_TDATA;
            awlen_d = 8'(plen_m1 >> BEAT_W);
            rem_d   = AXIS_PLEN_TDATA[BEAT_W-1:0];
            state_d = ST_AW;
          end else begin
            length_err = 1'b1;
            state_d    = ST_DRAIN;
          end
        end
      end
      ST_AW: begin
        M_AXI_AWVALID = 1'b1;
        M_AXI_AWADDR  = addr_q;
        M_AXI_AWLEN   = awlen_q;
        M_AXI_AWSIZE  = 3'(BEAT_W);
        M_AXI_AWBURST = AXI_BURST_INCR;
        M_AXI_AWID    = 4'(AXI_ID);
        if (M_AXI_AWREADY) begin
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        M_AXI_WVALID     = AXIS_DATA_TVALID;
        M_AXI_WDATA      = AXIS_DATA_TDATA;
        M_AXI_WSTRB      = last_beat ? last_strb : '1;
        M_AXI_WLAST      = last_beat;
        AXIS_DATA_TREADY = M_AXI_WREADY;
        if (AXIS_DATA_TVALID && M_AXI_WREADY) begin
          if (last_beat) begin
            if (AXIS_DATA_TLAST) begin
              state_d = ST_RESP;
            end else begin
              length_err = 1'b1;
              state_d    = ST_DRAIN_W;
            end
          end else begin
            beat_d = beat_q + 8'd1;
            if (AXIS_DATA_TLAST) begin
              length_err = 1'b1;
              state_d    = ST_PAD;
            end
          end
        end
      end
      ST_PAD: begin
        // Finish the promised burst length with empty beats.
        M_AXI_WVALID = 1'b1;
        M_AXI_WLAST  = last_beat;
        if (M_AXI_WREADY) begin
          if (last_beat) state_d = ST_RESP;
          else           beat_d  = beat_q + 8'd1;
        end
      end
      ST_DRAIN_W: begin
        // Burst already complete; discard the stream tail before taking B.
        AXIS_DATA_TREADY = 1'b1;
        if (AXIS_DATA_TVALID && AXIS_DATA_TLAST) state_d = ST_RESP;
      end
      ST_DRAIN: begin
        AXIS_DATA_TREADY = 1'b1;
        if (AXIS_DATA_TVALID && AXIS_DATA_TLAST) state_d = ST_IDLE;
      end
      ST_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          bresp_err = (M_AXI_BRESP != AXI_RESP_OKAY);
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign AXIS_ADDR_TREADY = hdr_rdy;
  assign AXIS_PLEN_TREADY = hdr_rdy;
  assign busy             = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      run_q   <= run_d;
    end
  end

  // Burst descriptor holds only data; it is rewritten before every use.
  always_ff @(posedge clk) begin
    addr_q  <= addr_d;
    awlen_q <= awlen_d;
    rem_q   <= rem_d;
  end

`ifdef RDMX_RECV_BE_STATS_EN
  logic [31:0] pkt_count_q, pkt_count_d;
  logic [31:0] err_count_q, err_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q + {31'd0, (M_AXI_BVALID && M_AXI_BREADY)};
    err_count_d = err_count_q + {31'd0, length_err} + {31'd0, bresp_err};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pkt_count_q <= '0;
      err_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
      err_count_q <= err_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
  assign err_count = err_count_q;
`else
  assign pkt_count = '0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_rdmx_recv_be.sv
// Randomised bench for rdmx_recv_be (512-bit data, 64-bit address).
module tb_rdmx_recv_be;
  import rdmx_pkg::*;

  localparam int DW = 512;
  localparam int AWD = 64;
`ifdef RDMX_RECV_BE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef logic [511:0] v_t;
  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
  } aw_rec_t;
  typedef struct {
    logic [DW-1:0]   data;
    logic [DW/8-1:0] strb;
    logic            last;
  } w_rec_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [AWD-1:0]  addr_tdata = '0;
  logic            addr_tvalid = 1'b0, addr_tready;
  logic [15:0]     plen_tdata = '0;
  logic            plen_tvalid = 1'b0, plen_tready;
  logic [DW-1:0]   data_tdata = '0;
  logic            data_tlast = 1'b0, data_tvalid = 1'b0, data_tready;
  logic [AWD-1:0]  awaddr;
  logic [7:0]      awlen;
  logic [2:0]      awsize;
  logic [1:0]      awburst;
  logic [3:0]      awid;
  logic            awvalid, awready = 1'b0;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready = 1'b0;
  logic [1:0]      bresp = 2'b00;
  logic            bvalid = 1'b0, bready;
  logic            length_err, bresp_err, busy;
  logic [31:0]     pkt_count, err_count;

  rdmx_recv_be #(.DATA_WBITS(DW), .ADDR_WBITS(AWD), .AXI_ID(0)) dut (
    .clk(clk), .resetn(resetn),
    .AXIS_ADDR_TDATA(addr_tdata), .AXIS_ADDR_TVALID(addr_tvalid), .AXIS_ADDR_TREADY(addr_tready),
    .AXIS_PLEN_TDATA(plen_tdata), .AXIS_PLEN_TVALID(plen_tvalid), .AXIS_PLEN_TREADY(plen_tready),
    .AXIS_DATA_TDATA(data_tdata), .AXIS_DATA_TLAST(data_tlast),
    .AXIS_DATA_TVALID(data_tvalid), .AXIS_DATA_TREADY(data_tready),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWID(awid), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .length_err(length_err), .bresp_err(bresp_err), .busy(busy),
    .pkt_count(pkt_count), .err_count(err_count)
  );

  int checks = 0, errors = 0;
  int exp_pkt = 0, exp_err = 0;
  aw_rec_t aw_log[$];
  w_rec_t  w_log[$];
  aw_rec_t aw_r;
  w_rec_t  w_r;
  int w_last_cnt = 0, b_hs_cnt = 0, lerr_cnt = 0, berr_cnt = 0, b_issued = 0;
  logic [1:0] next_bresp = 2'b00;
  bit stall_en = 1'b0;
  logic [DW-1:0] pkt_data [0:15];

  task automatic check(input string tag, input v_t got, input v_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Observe every handshake and pulse at the falling edge, where all signals are settled.
  always @(negedge clk) begin
    if (awvalid && awready) begin
      aw_r.addr = awaddr; aw_r.len = awlen; aw_r.size = awsize;
      aw_r.burst = awburst; aw_r.id = awid;
      aw_log.push_back(aw_r);
    end
    if (wvalid && wready) begin
      w_r.data = wdata; w_r.strb = wstrb; w_r.last = wlast;
      w_log.push_back(w_r);
      if (wlast) w_last_cnt++;
    end
    if (bvalid && bready) b_hs_cnt++;
    if (length_err) lerr_cnt++;
    if (bresp_err) berr_cnt++;
  end

  // AXI slave: random ready stalls, one B per completed burst.
  always @(posedge clk) begin
    #1;
    awready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    wready  = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!resetn) begin
      bvalid   = 1'b0;
      b_issued = w_last_cnt;
    end else if (bvalid) begin
      if (b_hs_cnt == b_issued) bvalid = 1'b0;
    end else if (w_last_cnt > b_issued && (!stall_en || $urandom_range(0, 1) == 1)) begin
      bvalid = 1'b1;
      bresp  = next_bresp;
      b_issued++;
    end
  end

  task automatic drive_hdr(input logic [63:0] addr, input logic [15:0] plen);
    int n = 0;
    bit hs = 1'b0;
    addr_tdata = addr; plen_tdata = plen;
    addr_tvalid = 1'b1; plen_tvalid = 1'b1;
    while (!hs && n < 500) begin
      @(negedge clk);
      hs = addr_tready && plen_tready;
      @(posedge clk); #1;
      n++;
    end
    addr_tvalid = 1'b0; plen_tvalid = 1'b0;
    check("hdr_accept", v_t'(hs), v_t'(1));
  endtask

  task automatic drive_data(input int nb);
    for (int i = 0; i < nb; i++) begin
      bit hs = 1'b0;
      int t = 0;
      if (stall_en) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      data_tvalid = 1'b1; data_tdata = pkt_data[i]; data_tlast = (i == nb - 1);
      while (!hs && t < 500) begin
        @(negedge clk);
        hs = data_tready;
        @(posedge clk); #1;
        t++;
      end
      data_tvalid = 1'b0; data_tlast = 1'b0;
      if (!hs) begin
        check("data_accept", v_t'(0), v_t'(1));
        return;
      end
    end
  endtask

  task automatic run_pkt(input logic [63:0] addr, input int plen, input int nb, input logic [1:0] br);
    int aw0 = aw_log.size();
    int w0  = w_log.size();
    int b0  = b_hs_cnt;
    int le0 = lerr_cnt;
    int be0 = berr_cnt;
    bit legal = (plen >= 1) && (plen <= MAX_PLEN);
    int beats = (plen + BPB - 1) / BPB;
    int last_bytes = plen - (beats - 1) * BPB;
    int exp_le;
    int t = 0;
    logic [63:0] mask;
    for (int i = 0; i < nb; i++)
      for (int j = 0; j < 16; j++) pkt_data[i][j*32 +: 32] = $urandom();
    next_bresp = br;
    fork
      drive_hdr(addr, 16'(plen));
      drive_data(nb);
    join
    do begin @(negedge clk); t++; end while (busy && t < 2000);
    check("return_idle", v_t'(busy), v_t'(0));
    @(posedge clk); #1;

    exp_le = (!legal || nb != beats) ? 1 : 0;
    check("length_err", v_t'(lerr_cnt - le0), v_t'(exp_le));
    if (legal) begin
      mask = (last_bytes == BPB) ? '1 : ((64'd1 << last_bytes) - 64'd1);
      check("aw_count", v_t'(aw_log.size() - aw0), v_t'(1));
      if (aw_log.size() > aw0) begin
        check("awaddr",  v_t'(aw_log[aw0].addr),  v_t'(addr));
        check("awlen",   v_t'(aw_log[aw0].len),   v_t'(beats - 1));
        check("awsize",  v_t'(aw_log[aw0].size),  v_t'(BEAT_WBITS));
        check("awburst", v_t'(aw_log[aw0].burst), v_t'(1));
        check("awid",    v_t'(aw_log[aw0].id),    v_t'(0));
      end
      check("w_count", v_t'(w_log.size() - w0), v_t'(beats));
      if (w_log.size() >= w0 + beats) begin
        for (int i = 0; i < beats; i++) begin
          v_t ed = (i < nb) ? v_t'(pkt_data[i]) : v_t'(0);
          v_t es = (i >= nb) ? v_t'(0) : ((i == beats - 1) ? v_t'(mask) : v_t'({64{1'b1}}));
          check("wdata", v_t'(w_log[w0 + i].data), ed);
          check("wstrb", v_t'(w_log[w0 + i].strb), es);
          check("wlast", v_t'(w_log[w0 + i].last), v_t'(i == beats - 1));
        end
      end
      check("b_count",   v_t'(b_hs_cnt - b0),  v_t'(1));
      check("bresp_err", v_t'(berr_cnt - be0), v_t'(br != 2'b00));
      exp_pkt++;
      exp_err += exp_le + ((br != 2'b00) ? 1 : 0);
    end else begin
      check("aw_none", v_t'(aw_log.size() - aw0), v_t'(0));
      check("w_none",  v_t'(w_log.size() - w0),   v_t'(0));
      check("b_none",  v_t'(b_hs_cnt - b0),       v_t'(0));
      exp_err += 1;
    end
    check("pkt_count", v_t'(pkt_count), STATS ? v_t'(exp_pkt) : v_t'(0));
    check("err_count", v_t'(err_count), STATS ? v_t'(exp_err) : v_t'(0));
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_awvalid"}, v_t'(awvalid), v_t'(0));
    check({tag, "_wvalid"},  v_t'(wvalid),  v_t'(0));
    check({tag, "_bready"},  v_t'(bready),  v_t'(0));
    check({tag, "_treadys"}, v_t'({addr_tready, plen_tready, data_tready}), v_t'(0));
    check({tag, "_busy"},    v_t'(busy),    v_t'(0));
    check({tag, "_pulses"},  v_t'({length_err, bresp_err}), v_t'(0));
    check({tag, "_counts"},  v_t'({pkt_count, err_count}), v_t'(0));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    // Header offered during reset must not be taken.
    addr_tdata = 64'h1000; plen_tdata = 16'd64;
    addr_tvalid = 1'b1; plen_tvalid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    addr_tvalid = 1'b0; plen_tvalid = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;

    run_pkt(64'h1000, 64, 1, 2'b00);       // single full beat
    run_pkt(64'h2000, 200, 4, 2'b00);      // partial last beat
    run_pkt(64'h3000, 256, 2, 2'b00);      // early TLAST -> padding
    run_pkt(64'h4000, 64, 3, 2'b00);       // stream longer than PLEN -> drained
    run_pkt(64'h5000, 128, 2, 2'b00);      // clean packet after drain
    run_pkt(64'h6000, 0, 2, 2'b00);        // zero length
    run_pkt(64'h7000, 20000, 2, 2'b00);    // oversize length
    run_pkt(64'h8000, MAX_PLEN, 256, 2'b00); // maximum burst
    run_pkt(64'h9000, 128, 2, 2'b10);      // SLVERR response

    stall_en = 1'b1;
    for (int k = 0; k < 25; k++) begin
      int plen = (k % 9 == 8) ? 0 : $urandom_range(1, 512);
      int beats = (plen + BPB - 1) / BPB;
      int nb = ($urandom_range(0, 3) == 0 || beats == 0) ? $urandom_range(1, 9) : beats;
      logic [1:0] br = ($urandom_range(0, 7) == 0) ? 2'b10 : 2'b00;
      run_pkt({$urandom(), $urandom()}, plen, nb, br);
    end

    // Reset in the middle of a burst.
    stall_en = 1'b0;
    for (int j = 0; j < 16; j++) pkt_data[0][j*32 +: 32] = $urandom();
    drive_hdr(64'hA000, 16'd256);
    data_tvalid = 1'b1; data_tdata = pkt_data[0]; data_tlast = 1'b0;
    t = 0;
    do begin @(negedge clk); t++; end while (!(wvalid && wready) && t < 100);
    check("mid_burst_reached", v_t'(wvalid && wready), v_t'(1));
    @(posedge clk); #3;
    resetn = 1'b0;
    #1;
    check_quiet("async_reset");
    check("async_reset_wlast", v_t'({wlast, wstrb}), v_t'(0));
    data_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    exp_pkt = 0; exp_err = 0;
    @(posedge clk); #1;
    run_pkt(64'hB000, 130, 3, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
